// File: rtl/idec_pipe_pkg.sv
// Shared definitions for the instruction decode pipe.
// pkg_en: data width; pkg_bram_if: opcode enum, field positions, ID width.

package pkg_en;

   localparam int WIDTH_DATA = 32;

endpackage

package pkg_bram_if;

   localparam int WIDTH_AID  = 8;
   localparam int WIDTH_OP   = 4;
   localparam int WIDTH_FUNC = 4;

   localparam int POS_OPCODE = 0;
   localparam int POS_FUNC   = 4;
   localparam int POS_ADSTID = 8;
   localparam int POS_ASRCID = 16;

   typedef enum logic [WIDTH_OP-1:0] {
      OP_NOP  = 4'h0,
      OP_CTRL = 4'h1,
      OP_MOVE = 4'h3
   } opcode_e;

endpackage

// File: rtl/idec_fifo.sv
// Instruction FIFO: DEPTH x WIDTH, registered occupancy, full/empty flags.
// Ports: clk, rst (sync, active high), wrEn/wrData, rdEn, rdData (head), full, empty.

module idec_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wrEn,
   input  logic [WIDTH-1:0] wrData,
   input  logic             rdEn,
   output logic [WIDTH-1:0] rdData,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr;
   logic [AW-1:0]    rdPtr;
   logic [CW-1:0]    cnt;
   logic             doWr;
   logic             doRd;

   // A full FIFO refuses writes even when a read frees a slot this cycle.
   assign full  = (cnt == CW'(DEPTH));
   assign empty = (cnt == '0);
   assign doWr  = wrEn & ~full;
   assign doRd  = rdEn & ~empty;

   assign rdData = mem[rdPtr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr <= '0;
         rdPtr <= '0;
         cnt   <= '0;
      end else begin
         if (doWr) wrPtr <= wrPtr + 1'b1;
         if (doRd) rdPtr <= rdPtr + 1'b1;
         cnt <= cnt + CW'(doWr) - CW'(doRd);
      end
   end

   always_ff @(posedge clk) begin
      if (doWr) mem[wrPtr] <= wrData;
   end

endmodule

// File: rtl/idec_pipe.sv
// Instruction decode pipe: FIFO -> decode -> issue register, with a move
// pending table that stalls moves when full or on a WAR ID hazard.
// Ports: I_CLK, I_RST (sync, high); I_Instr_Valid/I_Instr/O_Instr_Ready in;
// O_Issue_Valid/I_Issue_Ready + decoded fields out; I_Move_Done retires the
// oldest move; O_Pend_Full; O_Err (sticky).
// Option: IDEC_WAR_CHECK_EN enables the ADstID vs pending ASrcID check.

module idec_pipe
   import pkg_en::*;
   import pkg_bram_if::*;
#(
   parameter int DEPTH_FIFO = 4,
   parameter int NUM_PEND   = 4
) (
   input  logic                  I_CLK,
   input  logic                  I_RST,
   input  logic                  I_Instr_Valid,
   input  logic [WIDTH_DATA-1:0] I_Instr,
   output logic                  O_Instr_Ready,
   output logic                  O_Issue_Valid,
   input  logic                  I_Issue_Ready,
   output logic                  O_OpCode_Move,
   output logic                  O_OpCode_Ctrl,
   output logic [WIDTH_FUNC-1:0] O_Func,
   output logic                  O_WAR_NEn,
   output logic [WIDTH_AID-1:0]  O_ADstID,
   output logic [WIDTH_AID-1:0]  O_ASrcID,
   input  logic                  I_Move_Done,
   output logic                  O_Pend_Full,
   output logic                  O_Err
);

   localparam int PCW = $clog2(NUM_PEND + 1);

   logic [WIDTH_DATA-1:0] head;
   logic                  fifoFull;
   logic                  fifoEmpty;

   logic [WIDTH_OP-1:0]   headOp;
   logic [WIDTH_FUNC-1:0] headFunc;
   logic [WIDTH_AID-1:0]  headAdst;
   logic [WIDTH_AID-1:0]  headAsrc;
   logic                  headWar;

   logic isNop;
   logic isCtrl;
   logic isMove;
   logic isRsvd;

   logic stall;
   logic warStall;
   logic load;
   logic drop;
   logic pop;
   logic alloc;
   logic retire;
   logic strayDone;

   logic [PCW-1:0] pendCnt;
   logic [PCW-1:0] pendCntNxt;

   logic unusedHeadBits;

   idec_fifo #(
      .DEPTH (DEPTH_FIFO),
      .WIDTH (WIDTH_DATA)
   ) uFifo (
      .clk    (I_CLK),
      .rst    (I_RST),
      .wrEn   (I_Instr_Valid),
      .wrData (I_Instr),
      .rdEn   (pop),
      .rdData (head),
      .full   (fifoFull),
      .empty  (fifoEmpty)
   );

   assign O_Instr_Ready = ~fifoFull;

   assign headOp   = head[POS_OPCODE +: WIDTH_OP];
   assign headFunc = head[POS_FUNC +: WIDTH_FUNC];
   assign headAdst = head[POS_ADSTID +: WIDTH_AID];
   assign headAsrc = head[POS_ASRCID +: WIDTH_AID];
   assign headWar  = head[WIDTH_DATA-1];

   assign unusedHeadBits =
      ^head[WIDTH_DATA-2:POS_ASRCID+WIDTH_AID];

   always_comb begin
      isNop  = 1'b0;
      isCtrl = 1'b0;
      isMove = 1'b0;
      isRsvd = 1'b0;
      unique case (1'b1)
         (headOp == OP_NOP):  isNop  = 1'b1;
         (headOp == OP_CTRL): isCtrl = 1'b1;
         (headOp == OP_MOVE): isMove = 1'b1;
         default:             isRsvd = 1'b1;
      endcase
   end

   assign retire    = I_Move_Done & (pendCnt != '0);
   assign strayDone = I_Move_Done & (pendCnt == '0);

`ifdef IDEC_WAR_CHECK_EN
   localparam int PAW = (NUM_PEND > 1) ? $clog2(NUM_PEND) : 1;

   logic [WIDTH_AID-1:0] pendSrc [NUM_PEND];
   logic [NUM_PEND-1:0]  pendVld;
   logic [PAW-1:0]       pendWp;
   logic [PAW-1:0]       pendRp;
   logic                 warHit;

   function automatic logic [PAW-1:0] nextPtr(
      input logic [PAW-1:0] p
   );
      return (p == PAW'(NUM_PEND - 1)) ? '0 : p + 1'b1;
   endfunction

   // Only registered entries count; an entry retiring this
   // cycle still blocks, so the move issues the cycle after.
   always_comb begin
      warHit = 1'b0;
      for (int i = 0; i < NUM_PEND; i++) begin
         if (pendVld[i] && (pendSrc[i] == headAdst))
            warHit = 1'b1;
      end
   end

   assign warStall = ~headWar & warHit;

   // Alloc is written after retire so that a full table
   // reusing the retiring slot keeps the new entry valid.
   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         pendVld <= '0;
         pendWp  <= '0;
         pendRp  <= '0;
      end else begin
         if (retire) begin
            pendVld[pendRp] <= 1'b0;
            pendRp          <= nextPtr(pendRp);
         end
         if (alloc) begin
            pendVld[pendWp] <= 1'b1;
            pendSrc[pendWp] <= headAsrc;
            pendWp          <= nextPtr(pendWp);
         end
      end
   end
`else
   assign warStall = 1'b0;
`endif

   // A full table with a same-cycle retire still has room.
   assign stall = isMove &
      ((O_Pend_Full & ~I_Move_Done) | warStall);

   assign load = ~fifoEmpty & (isCtrl | isMove) &
      (~O_Issue_Valid | I_Issue_Ready) & ~stall;
   assign drop  = ~fifoEmpty & (isNop | isRsvd);
   assign pop   = load | drop;
   assign alloc = load & isMove;

   assign pendCntNxt = pendCnt + PCW'(alloc) - PCW'(retire);

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         pendCnt     <= '0;
         O_Pend_Full <= 1'b0;
      end else begin
         pendCnt     <= pendCntNxt;
         O_Pend_Full <= (pendCntNxt == PCW'(NUM_PEND));
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         O_Issue_Valid <= 1'b0;
         O_OpCode_Move <= 1'b0;
         O_OpCode_Ctrl <= 1'b0;
         O_Func        <= '0;
         O_WAR_NEn     <= 1'b0;
         O_ADstID      <= '0;
         O_ASrcID      <= '0;
      end else if (load) begin
         O_Issue_Valid <= 1'b1;
         O_OpCode_Move <= isMove;
         O_OpCode_Ctrl <= isCtrl;
         O_Func        <= headFunc;
         O_WAR_NEn     <= headWar;
         O_ADstID      <= headAdst;
         O_ASrcID      <= headAsrc;
      end else if (I_Issue_Ready) begin
         O_Issue_Valid <= 1'b0;
      end
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST)
         O_Err <= 1'b0;
      else if ((drop & isRsvd) | strayDone)
         O_Err <= 1'b1;
   end

endmodule

// File: tb/tb_idec_pipe.sv
// Directed bench for idec_pipe (DEPTH_FIFO=4, NUM_PEND=2) with an
// in-order scoreboard of issued instructions.

module tb_idec_pipe;

   logic        I_CLK;
   logic        I_RST;
   logic        I_Instr_Valid;
   logic [31:0] I_Instr;
   logic        O_Instr_Ready;
   logic        O_Issue_Valid;
   logic        I_Issue_Ready;
   logic        O_OpCode_Move;
   logic        O_OpCode_Ctrl;
   logic [3:0]  O_Func;
   logic        O_WAR_NEn;
   logic [7:0]  O_ADstID;
   logic [7:0]  O_ASrcID;
   logic        I_Move_Done;
   logic        O_Pend_Full;
   logic        O_Err;

   int nCmp = 0;
   int nErr = 0;
   logic [31:0] sbq [$];

   idec_pipe #(
      .DEPTH_FIFO (4),
      .NUM_PEND   (2)
   ) dut (
      .I_CLK         (I_CLK),
      .I_RST         (I_RST),
      .I_Instr_Valid (I_Instr_Valid),
      .I_Instr       (I_Instr),
      .O_Instr_Ready (O_Instr_Ready),
      .O_Issue_Valid (O_Issue_Valid),
      .I_Issue_Ready (I_Issue_Ready),
      .O_OpCode_Move (O_OpCode_Move),
      .O_OpCode_Ctrl (O_OpCode_Ctrl),
      .O_Func        (O_Func),
      .O_WAR_NEn     (O_WAR_NEn),
      .O_ADstID      (O_ADstID),
      .O_ASrcID      (O_ASrcID),
      .I_Move_Done   (I_Move_Done),
      .O_Pend_Full   (O_Pend_Full),
      .O_Err         (O_Err)
   );

   initial I_CLK = 1'b0;
   always #5 I_CLK = ~I_CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      nCmp++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(
      input logic       war,
      input logic [7:0] asrc,
      input logic [7:0] adst,
      input logic [3:0] func,
      input logic [3:0] op);
      return {war, 7'b0, asrc, adst, func, op};
   endfunction

   task automatic tick();
      @(posedge I_CLK);
      #1;
   endtask

   task automatic send(input logic [31:0] w, input bit exp);
      bit ok;
      bit got;
      got = 1'b0;
      I_Instr_Valid = 1'b1;
      I_Instr = w;
      for (int i = 0; i < 50; i++) begin
         ok = O_Instr_Ready;
         tick();
         if (ok) begin
            got = 1'b1;
            break;
         end
      end
      I_Instr_Valid = 1'b0;
      check("send_accept", 32'(got), 32'd1);
      if (got && exp) sbq.push_back(w);
   endtask

   task automatic done();
      I_Move_Done = 1'b1;
      tick();
      I_Move_Done = 1'b0;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 30 && sbq.size() != 0; i++) tick();
      check(tag, 32'(sbq.size()), 32'd0);
   endtask

   // Handshake seen mid-cycle completes at the next rising edge.
   always @(negedge I_CLK) begin
      logic [31:0] e;
      if (!I_RST && O_Issue_Valid && I_Issue_Ready) begin
         nCmp++;
         assert (sbq.size() != 0) else begin
            nErr++;
            $error("FAIL unexpected_issue: observed func %0h expected none",
                   O_Func);
         end
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            nCmp--;
            check("issue_fields",
               32'({O_OpCode_Move, O_OpCode_Ctrl, O_Func,
                    O_WAR_NEn, O_ADstID, O_ASrcID}),
               32'({e[3:0] == 4'h3, e[3:0] == 4'h1, e[7:4],
                    e[31], e[15:8], e[23:16]}));
         end
      end
   end

   logic [31:0] w [6];
   int acc;
   bit ok;

   initial begin
      I_RST = 1'b1;
      I_Instr_Valid = 1'b0;
      I_Instr = '0;
      I_Issue_Ready = 1'b0;
      I_Move_Done = 1'b0;
      tick();
      tick();
      I_RST = 1'b0;

      // reset state
      check("rst_valid", 32'(O_Issue_Valid), 0);
      check("rst_ready", 32'(O_Instr_Ready), 1);
      check("rst_pfull", 32'(O_Pend_Full), 0);
      check("rst_err", 32'(O_Err), 0);
      check("rst_fields", 32'({O_OpCode_Move, O_OpCode_Ctrl,
         O_Func, O_WAR_NEn, O_ADstID, O_ASrcID}), 0);

      // single move, latency 1
      I_Issue_Ready = 1'b1;
      send(mk(0, 8'd5, 8'd2, 4'h6, 4'h3), 1);
      check("lat_nobypass", 32'(O_Issue_Valid), 0);
      tick();
      check("lat_valid", 32'(O_Issue_Valid), 1);
      check("lat_move", 32'(O_OpCode_Move), 1);
      check("lat_ids", 32'({O_ADstID, O_ASrcID}), 32'h0205);
      check("lat_pcnt", 32'(dut.pendCnt), 1);
      tick();
      done();
      check("ret_pcnt", 32'(dut.pendCnt), 0);

      // WAR hazard on ASrcID 5
      send(mk(1, 8'd5, 8'd1, 4'h0, 4'h3), 1);
      tick();
      tick();
      send(mk(0, 8'd3, 8'd5, 4'h1, 4'h3), 1);
`ifdef IDEC_WAR_CHECK_EN
      repeat (3) tick();
      check("war_stall", 32'(O_Issue_Valid), 0);
      done();
      check("war_hold", 32'(O_Issue_Valid), 0);
      tick();
      check("war_release", 32'(O_Issue_Valid), 1);
`else
      tick();
      check("war_nocheck", 32'(O_Issue_Valid), 1);
      done();
`endif
      tick();
      check("war_pcnt", 32'(dut.pendCnt), 1);
      done();

      // WAR_NEn=1 issues past a matching entry
      send(mk(1, 8'd5, 8'd0, 4'h2, 4'h3), 1);
      tick();
      send(mk(1, 8'd6, 8'd5, 4'h3, 4'h3), 1);
      tick();
      check("nen_issue", 32'(O_Issue_Valid), 1);
      check("nen_pfull", 32'(O_Pend_Full), 1);
      tick();
      done();
      done();
      check("nen_pfull_clr", 32'(O_Pend_Full), 0);

      // backpressure: 6 offered, FIFO plus output reg take 5
      I_Issue_Ready = 1'b0;
      for (int i = 0; i < 6; i++)
         w[i] = mk(1'(i), 8'(8'h20 + i), 8'(8'h10 + i),
                   4'(i + 1), 4'h1);
      acc = 0;
      I_Instr_Valid = 1'b1;
      for (int c = 0; c < 12 && acc < 6; c++) begin
         I_Instr = w[acc];
         ok = O_Instr_Ready;
         tick();
         if (ok) begin
            sbq.push_back(w[acc]);
            acc++;
         end
      end
      I_Instr_Valid = 1'b0;
      check("bp_accepted", 32'(acc), 5);
      check("bp_ready", 32'(O_Instr_Ready), 0);
      check("bp_hold1", 32'({O_Issue_Valid, O_Func, O_ADstID}),
            32'h1110);
      repeat (3) tick();
      check("bp_hold2", 32'({O_Issue_Valid, O_Func, O_ADstID}),
            32'h1110);
      I_Issue_Ready = 1'b1;
      drain("bp_drain");

      // NOP and reserved are dropped; reserved flags error
      check("err_pre", 32'(O_Err), 0);
      send(mk(0, 8'd0, 8'd0, 4'h0, 4'h0), 0);
      send(mk(0, 8'd0, 8'd0, 4'h0, 4'h7), 0);
      check("err_before_pop", 32'(O_Err), 0);
      send(mk(0, 8'h44, 8'h33, 4'h9, 4'h1), 1);
      check("err_set", 32'(O_Err), 1);
      drain("rsv_drain");

      // full table, third move allocates with same-cycle retire
      send(mk(1, 8'd1, 8'd0, 4'h0, 4'h3), 1);
      send(mk(1, 8'd2, 8'd0, 4'h0, 4'h3), 1);
      send(mk(1, 8'd3, 8'd7, 4'h0, 4'h3), 1);
      check("full_pfull", 32'(O_Pend_Full), 1);
      tick();
      tick();
      check("full_stall", 32'(O_Issue_Valid), 0);
      check("full_pcnt", 32'(dut.pendCnt), 2);
      done();
      check("full_issue", 32'({O_Issue_Valid, O_ADstID}), 32'h107);
      check("full_pcnt2", 32'(dut.pendCnt), 2);
      check("full_pfull2", 32'(O_Pend_Full), 1);
      tick();
      done();
      done();

      // reset mid-operation
      send(mk(1, 8'd1, 8'd0, 4'h0, 4'h3), 1);
      send(mk(1, 8'd2, 8'd0, 4'h0, 4'h3), 1);
      tick();
      tick();
      I_Issue_Ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(mk(0, 8'd9, 8'd8, 4'(i), 4'h1), 1);
      check("pre_rst_valid", 32'(O_Issue_Valid), 1);
      check("pre_rst_pcnt", 32'(dut.pendCnt), 2);
      I_RST = 1'b1;
      I_Instr_Valid = 1'b1;
      I_Instr = mk(0, 8'd1, 8'd1, 4'h1, 4'h1);
      tick();
      I_RST = 1'b0;
      I_Instr_Valid = 1'b0;
      sbq.delete();
      check("mid_rst_outs", 32'({O_Issue_Valid, O_OpCode_Move,
         O_OpCode_Ctrl, O_Func, O_WAR_NEn, O_ADstID, O_ASrcID}), 0);
      check("mid_rst_flags", 32'({O_Pend_Full, O_Err}), 0);
      check("mid_rst_ready", 32'(O_Instr_Ready), 1);
      I_Issue_Ready = 1'b1;
      repeat (3) tick();
      check("mid_rst_empty", 32'(O_Issue_Valid), 0);
      check("mid_rst_pcnt", 32'(dut.pendCnt), 0);
      done();
      check("stray_done_err", 32'(O_Err), 1);

      tick();
      check("final_sb", 32'(sbq.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               nCmp, nErr);
      $finish;
   end

endmodule
